shiftrows: RTL and testbench
============================

# shiftrows

AES ShiftRows transformation stage. It takes a 128-bit AES state and cyclically left-rotates row r by r byte positions. The result is registered through a fixed-latency pipeline with a valid flag travelling alongside the data. It sits in the AES round datapath between SubBytes and MixColumns, and is also used in the final round, where MixColumns is skipped. There is no backpressure.

## Interface
Parameters:
- LATENCY, default 1: number of register stages from input to output. Legal range is 1..4; any other value is an elaboration error.

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- i_valid, input, 1: i_block is valid this cycle.
- i_block, input, 128: input state.
- o_valid, output, 1: o_block is valid this cycle.
- o_block, output, 128: ShiftRows result.

## Operation
- Byte numbering:
  - b0 = i_block[127:120], b1 = i_block[119:112], continuing down to b15 = i_block[7:0].
  - State is column-major: column c = {b(4c), b(4c+1), b(4c+2), b(4c+3)}, and the first byte of each column is row 0.
- Output mapping, MSB to LSB:
  - Column 0: b0, b5, b10, b15
  - Column 1: b4, b9, b14, b3
  - Column 2: b8, b13, b2, b7
  - Column 3: b12, b1, b6, b11
- The permutation is pure wiring (combinational) and sits ahead of the first register stage. It has no arithmetic and no width change.
- Pipeline structure: LATENCY stages, each holding a 1-bit valid and a 128-bit data word.
  - The valid bit shifts every cycle unconditionally.
  - A data register loads only when the valid entering that stage is 1; otherwise it holds its value.
- A new block may be accepted every cycle, so throughput is one block per clock.
- Back-to-back inputs emerge back-to-back, in order, with no loss or duplication.
- Any number of idle cycles may separate inputs.
- i_block is ignored (don't-care) whenever i_valid = 0.

## Timing
- Input i_valid/i_block is sampled at rising edge N; o_valid = 1 with the matching o_block from edge N+LATENCY−1 until edge N+LATENCY.
  - Default LATENCY = 1: outputs are valid in the cycle after sampling.
- o_valid is high for exactly one cycle per accepted input.
- Reset behaviour:
  - While rst = 0, regardless of clk: all valid bits are 0, so o_valid = 0.
  - All data registers are 128'h0, so o_block = 0.
- Reset asserted mid-operation discards every in-flight block immediately. No output appears for those blocks after release.
- On the first rising edge after rst deasserts, an i_valid = 1 input is accepted normally.
- Outputs are driven directly from registers, with no combinational path from input to output.

## Configuration
- Macro SHIFTROWS_OUT_CLR_EN.
- Defined: o_block is forced to 128'h0 on every cycle where o_valid = 0. This is an AND-gate on the output, or a clear of the last-stage data register.
- Undefined: o_block holds the last valid result until the next one arrives.
- o_valid timing and the data value on valid cycles are identical in both builds.

## Test plan
- Apply reset, then release -> o_valid = 0 and o_block = 0 during reset. No o_valid pulse until the first i_valid.
- Input 00010203_10111213_20212223_30313233 -> o_block = 00112233_10213203_20310213_30011223, with o_valid high for one cycle, LATENCY cycles after sampling.
- Input 00010203_04050607_08090A0B_0C0D0E0F -> 00050A0F_04090E03_080D0207_0C01060B.
- All-zeros input -> all-zeros output; all-FF input -> all-FF output; each with a single o_valid pulse.
- 64 back-to-back random inputs, with i_valid held high -> 64 consecutive o_valid cycles, each output matching the mapping above, in order.
- Assert rst for 1 cycle while 2 blocks are in flight, with LATENCY = 4 -> no o_valid for those blocks. The next input after release is produced correctly.
- Build with SHIFTROWS_OUT_CLR_EN defined -> o_block = 0 on idle cycles. Build without it -> o_block holds the previous result.

Source files
------------

// File: rtl/shiftrows.sv
// AES ShiftRows with a LATENCY-deep valid/data pipeline; the byte permutation is wiring ahead of stage 1.
// Build option SHIFTROWS_OUT_CLR_EN: zero o_block on cycles where o_valid is low.
module shiftrows_stage #(
  parameter int W   = 128,
  parameter bit CLR = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld_in,
  input  logic [W-1:0] d_in,
  output logic         vld_out,
  output logic [W-1:0] d_out
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_out <= 1'b0;
      d_out   <= '0;
    end else begin
      vld_out <= vld_in;
      // data only moves with a valid token; otherwise hold (or clear on the output stage)
      if (vld_in)   d_out <= d_in;
      else if (CLR) d_out <= '0;
    end
  end
endmodule

module shiftrows #(
  parameter int LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  input  logic [127:0] i_block,
  output logic         o_valid,
  output logic [127:0] o_block
);
  localparam int NUM_LANES = 4;   // columns (and rows) of the AES state
  localparam int VEC_W     = 8;
  localparam int BLK_W     = NUM_LANES*NUM_LANES*VEC_W;

`ifdef SHIFTROWS_OUT_CLR_EN
  localparam bit OUT_CLR = 1'b1;
`else
  localparam bit OUT_CLR = 1'b0;
`endif

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("shiftrows: LATENCY must be in 1..4");
  end

  // byte k of the block lives at index 15-k, so b0 is the MSB byte
  logic [NUM_LANES*NUM_LANES-1:0][VEC_W-1:0] in_b, perm_b;
  assign in_b = i_block;

  for (genvar c = 0; c < NUM_LANES; c++) begin : g_col
    for (genvar r = 0; r < NUM_LANES; r++) begin : g_row
      assign perm_b[15-(NUM_LANES*c+r)] = in_b[15-(NUM_LANES*((c+r)%NUM_LANES)+r)];
    end
  end

  logic [LATENCY:0] vld_pipe;
  logic [BLK_W-1:0] data_pipe [0:LATENCY];

  assign vld_pipe[0]  = i_valid;
  assign data_pipe[0] = perm_b;

  for (genvar s = 1; s <= LATENCY; s++) begin : g_stg
    shiftrows_stage #(
      .W   (BLK_W),
      .CLR (OUT_CLR && (s == LATENCY))
    ) u_stg (
      .clk     (clk),
      .rst     (rst),
      .vld_in  (vld_pipe[s-1]),
      .d_in    (data_pipe[s-1]),
      .vld_out (vld_pipe[s]),
      .d_out   (data_pipe[s])
    );
  end

  assign o_valid = vld_pipe[LATENCY];
  assign o_block = data_pipe[LATENCY];
endmodule

// File: tb/tb_shiftrows.sv
// Bench for shiftrows: LATENCY=1 and LATENCY=4 instances share stimulus and are checked every cycle
// against a timestamped model of accepted blocks.
module tb_shiftrows;
  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic [127:0] i_block;
  logic         o_valid1, o_valid4;
  logic [127:0] o_block1, o_block4;

  always #5 clk = ~clk;

  shiftrows #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_block(i_block),
    .o_valid(o_valid1), .o_block(o_block1));

  shiftrows #(.LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_block(i_block),
    .o_valid(o_valid4), .o_block(o_block4));

  int cmp_n = 0;
  int err_n = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // state[row][col] = b(4*col+row); row r rotates left by r
  function automatic logic [127:0] sr_ref(input logic [127:0] x);
    logic [7:0]   st [4][4];
    logic [127:0] y;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = x[127-8*(4*c+r) -: 8];
    y = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[127-8*(4*c+r) -: 8] = st[r][(c+r)%4];
    return y;
  endfunction

  // model: record every block accepted at edge index e; flush_e discards everything before a reset
  localparam int MAXE = 4096;
  bit           acc_v [MAXE];
  logic [127:0] acc_d [MAXE];
  int           ecount = 0;
  int           flush_e = 0;
  logic [127:0] last1 = '0, last4 = '0;

  always @(posedge clk) begin
    if (rst === 1'b1 && i_valid === 1'b1) begin
      acc_v[ecount] = 1'b1;
      acc_d[ecount] = sr_ref(i_block);
    end
    ecount++;
  end

  task automatic model_out(input int lat, inout logic [127:0] last, output bit ev);
    int idx;
    idx = ecount - lat;
    ev  = (idx >= 0) && (idx >= flush_e) && acc_v[idx];
    if (ev) last = acc_d[idx];
`ifdef SHIFTROWS_OUT_CLR_EN
    else    last = '0;
`endif
  endtask

  always @(negedge clk) begin
    bit ev1, ev4;
    if (rst !== 1'b1) begin
      last1 = '0;
      last4 = '0;
      check("rst_valid1", {127'b0, o_valid1}, '0);
      check("rst_block1", o_block1, '0);
      check("rst_valid4", {127'b0, o_valid4}, '0);
      check("rst_block4", o_block4, '0);
    end else begin
      model_out(1, last1, ev1);
      model_out(4, last4, ev4);
      check("valid_l1", {127'b0, o_valid1}, {127'b0, ev1});
      check("block_l1", o_block1, last1);
      check("valid_l4", {127'b0, o_valid4}, {127'b0, ev4});
      check("block_l4", o_block4, last4);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      i_valid = 1'b0;
      i_block = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
    end
  endtask

  task automatic send(input logic [127:0] blk);
    i_valid = 1'b1;
    i_block = blk;
    @(posedge clk); #1;
  endtask

  // hand-computed expectations, checked directly at the output for both latencies
  task automatic pin(input string nm, input logic [127:0] blk, input logic [127:0] exp);
    send(blk);
    i_valid = 1'b0;
    @(negedge clk);
    check({nm, "_v1"}, {127'b0, o_valid1}, 128'd1);
    check({nm, "_d1"}, o_block1, exp);
    repeat (3) @(negedge clk);
    check({nm, "_v4"}, {127'b0, o_valid4}, 128'd1);
    check({nm, "_d4"}, o_block4, exp);
    @(posedge clk); #1;
    idle(1);
  endtask

  initial begin
    rst     = 1'b0;
    i_valid = 1'b0;
    i_block = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(4);

    pin("vec_rows", 128'h00010203_10111213_20212223_30313233,
                    128'h00112233_10213203_20310213_30011223);
    pin("vec_seq",  128'h00010203_04050607_08090A0B_0C0D0E0F,
                    128'h00050A0F_04090E03_080D0207_0C01060B);
    pin("vec_zero", '0, '0);
    pin("vec_ones", {128{1'b1}}, {128{1'b1}});

    for (int i = 0; i < 64; i++) send({$urandom, $urandom, $urandom, $urandom});
    idle(6);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) != 0) send({$urandom, $urandom, $urandom, $urandom});
      else idle($urandom_range(1, 5));
    end
    idle(6);

    // two blocks in flight through the 4-deep pipe, then a one-cycle reset
    send({$urandom, $urandom, $urandom, $urandom});
    send({$urandom, $urandom, $urandom, $urandom});
    i_valid = 1'b0;
    rst     = 1'b0;
    flush_e = ecount;
    @(posedge clk); #1;
    rst = 1'b1;
    send(128'h00010203_04050607_08090A0B_0C0D0E0F);
    idle(8);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) != 0) send({$urandom, $urandom, $urandom, $urandom});
      else idle($urandom_range(1, 3));
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
